riscv_lsu: RTL and testbench
============================

# riscv_lsu

Load/store unit that answers the single-cycle core's data-memory request port and drives a byte-enabled, word-wide data memory with a ready handshake. It decodes access size, forms byte enables and replicated write data, and holds the core with `core_stall_o` until the memory accepts. It extracts and sign- or zero-extends load data and flags misaligned or illegal accesses. It sits between `processor_core` and the data RAM in the top-level system.

## Interface
Parameters:
- none; widths are fixed at 32-bit address and data.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; asynchronous, active-low.
- `core_req_i` in 1: core requests a data access. Held by the core while stalled.
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: funct3 size code: B=0, H=1, W=2, BU=4, HU=5.
- `core_addr_i` in 32: byte address.
- `core_wd_i` in 32: store data, LSB-aligned.
- `core_rd_o` out 32: extended load data.
- `core_stall_o` out 1: freeze the core (PC and register write).
- `lsu_err_o` out 1: access was misaligned or had an illegal size code.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: equals `core_addr_i`. The memory word-aligns it.
- `mem_wd_o` out 32: replicated store data.
- `mem_rd_i` in 32: read word, valid in the accept cycle.
- `mem_ready_i` in 1: accept. A transfer happens in any cycle where `mem_req_o & mem_ready_i`.

## Operation
- FSM states:
  - IDLE: start state.
    - `core_req_i`=0: stay IDLE, no request.
    - `core_req_i`=1 and the access is legal: assert `mem_req_o` and `core_stall_o`. Go to DONE if `mem_ready_i`, else go to WAIT.
    - `core_req_i`=1 and the access is illegal: no `mem_req_o`. Assert `core_stall_o` and go to DONE with the error flag set.
  - WAIT: hold `mem_req_o`=1 and `core_stall_o`=1. Go to DONE on `mem_ready_i`.
  - DONE: `mem_req_o`=0, `core_stall_o`=0. Drive `core_rd_o` from the capture registers and `lsu_err_o` from the error flag. Go to IDLE unconditionally. `core_req_i` is ignored in DONE, because it still reflects the committing instruction.
- Capture in the accept cycle, or the illegal-detect cycle: `rdata_q` ← `mem_rd_i` for loads; also register `off_q` (addr[1:0]), `size_q`, and `err_q`.
- Store formatting, for `mem_be_o` and `mem_wd_o`:
  - B: be = 4'b0001 << addr[1:0]; wd = {4{wd[7:0]}}.
  - H: be = addr[1] ? 4'b1100 : 4'b0011; wd = {2{wd[15:0]}}.
  - W: be = 4'b1111; wd = wd.
- Loads drive `mem_be_o` = 4'b1111.
- Load extraction, from `rdata_q`:
  - B/BU: select byte `off_q`; sign-extend for B, zero-extend for BU.
  - H/HU: select half `off_q[1]`; sign-extend for H, zero-extend for HU.
  - W: whole word.
- Illegal accesses:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Size codes 3, 6 or 7.
  - Stores with size 4 or 5.
- On an illegal access, `core_rd_o`=0 and `lsu_err_o`=1, asserted only during DONE.
- `mem_we_o` = `core_we_i` while `mem_req_o`=1, else 0.

## Timing
- Reset (`rst_i`=0, async): state=IDLE; `rdata_q`, `off_q`, `size_q`, `err_q` = 0.
- Outputs during reset: `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `core_stall_o`=0, `core_rd_o`=0, `lsu_err_o`=0.
- Reset mid-WAIT: the request drops immediately. No DONE cycle occurs.
- Request outputs (`mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o`, `mem_wd_o`, `core_stall_o`) are combinational from state and core inputs.
- `core_rd_o` and `lsu_err_o` are driven from registers only.
- Minimum access: 2 cycles, i.e. 1 stall cycle, when `mem_ready_i`=1 on the first cycle. Each extra not-ready cycle adds 1 stall cycle.
- Back-to-back accesses: at least one IDLE cycle separates them. The core commits at the end of DONE, so the next instruction appears in the following IDLE cycle.
- `mem_ready_i` outside a request is ignored.
- Address and data must stay stable while in WAIT. The core guarantees this through the stall.

## Structure
- Package `riscv_lsu_pkg`:
  - Size constants `LDST_B`, `LDST_H`, `LDST_W`, `LDST_BU`, `LDST_HU`.
  - State enum `lsu_state_t` {IDLE, WAIT, DONE}.
- Sub-module `lsu_load_extract`: combinational; inputs `rdata_q`, `off_q`, `size_q`; output the extended word.
- The FSM and store formatting stay in `riscv_lsu`.

## Test plan
- Load word, `mem_ready_i` tied 1:
  - Stimulus: addr 0x100, `mem_rd_i`=0xDEADBEEF.
  - Response: `core_stall_o`=1 for one cycle, then `core_rd_o`=0xDEADBEEF in DONE, `lsu_err_o`=0.
- SB then SH, ready=1:
  - SB to 0x103 with wd 0x000000A5 → be=1000, wd=0xA5A5A5A5.
  - SH to 0x102 with wd 0x1234 → be=1100, wd=0x12341234.
- Byte and halfword loads from word 0x80F0FF7F:
  - LB at offset 0 → 0x0000007F.
  - LB at offset 1 → 0xFFFFFFFF.
  - LBU at offset 2 → 0x000000F0.
  - LH at offset 2 → 0xFFFF80F0.
  - LHU at offset 2 → 0x000080F0.
- Wait states: `mem_ready_i` low for 3 cycles → 4 stall cycles, `mem_req_o` held with a stable address, data delivered in DONE.
- Misaligned LW at 0x102 → `mem_req_o` never asserted; DONE gives `lsu_err_o`=1, `core_rd_o`=0. The same holds for SH at 0x101.
- Async reset asserted in WAIT → stall and request drop immediately. After release the FSM is in IDLE and a new LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment/legality rule used by the request decoder.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Unsigned sizes only make sense for loads; halves and words must be naturally aligned.
    function automatic logic access_legal(input logic we, input logic [2:0] size,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (size)
            LDST_B:  ok = 1'b1;
            LDST_BU: ok = !we;
            LDST_H:  ok = !off[0];
            LDST_HU: ok = !we && !off[0];
            LDST_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-wide, byte-enabled data memory port. The LSU is the master, the RAM the slave.
interface riscv_lsu_if;
    // A transfer completes in every cycle where mem_req & mem_ready are both high;
    // the master holds req/we/be/addr/wd stable until then, and mem_rd is valid only in that cycle.
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wd,
        input  mem_rd, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wd,
        output mem_rd, mem_ready
    );
endinterface

// File: rtl/riscv_lsu_load_extract.sv
// Selects the addressed byte/half of a captured read word and sign- or
// zero-extends it according to the captured size code.
module lsu_load_extract
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata_q,
    input  logic [1:0]  off_q,
    input  logic [2:0]  size_q,
    output logic [31:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_q[7:0];
        case (off_q)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    always_comb begin
        ext_o = 32'd0;
        case (size_q)
            LDST_B:  ext_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: ext_o = {24'd0, byte_sel};
            LDST_H:  ext_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: ext_o = {16'd0, half_sel};
            LDST_W:  ext_o = rdata_q;
            default: ext_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between the single-cycle core and the data RAM: stalls the
// core until the memory accepts, formats stores and returns extended loads.
module riscv_lsu
    import riscv_lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        lsu_err_o,
    output lsu_state_t  dbg_state_o,
    riscv_lsu_if.master mem
);

    lsu_state_t  state_q, state_d;
    logic [31:0] rdata_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        err_q;

    logic        legal;
    logic        req;
    logic        stall;
    logic        accept;
    logic        illegal_hit;
    logic [3:0]  be;
    logic [31:0] wd_fmt;
    logic [31:0] ext_word;

    assign legal       = access_legal(core_we_i, core_size_i, core_addr_i[1:0]);
    assign illegal_hit = (state_q == IDLE) && core_req_i && !legal;
    assign accept      = req && mem.mem_ready;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    state_d = (!legal || mem.mem_ready) ? DONE : WAIT;
                end
            end
            WAIT:    if (mem.mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request and stall are combinational so the core freezes in the same cycle it asks.
    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        if (rst_i) begin
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        stall = 1'b1;
                        req   = legal;
                    end
                end
                WAIT: begin
                    stall = 1'b1;
                    req   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        be     = 4'b0000;
        wd_fmt = core_wd_i;
        case (core_size_i[1:0])
            2'd0:    wd_fmt = {4{core_wd_i[7:0]}};
            2'd1:    wd_fmt = {2{core_wd_i[15:0]}};
            default: wd_fmt = core_wd_i;
        endcase
        if (req) begin
            if (!core_we_i) begin
                be = 4'b1111;
            end else begin
                case (core_size_i[1:0])
                    2'd0:    be = 4'b0001 << core_addr_i[1:0];
                    2'd1:    be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    default: be = 4'b1111;
                endcase
            end
        end
    end

    assign mem.mem_req  = req;
    assign mem.mem_we   = req && core_we_i;
    assign mem.mem_be   = be;
    assign mem.mem_addr = core_addr_i;
    assign mem.mem_wd   = wd_fmt;
    assign core_stall_o = stall;

    // Stores and illegal accesses capture zero so DONE never shows stale read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= 32'd0;
            off_q   <= 2'd0;
            size_q  <= 3'd0;
            err_q   <= 1'b0;
        end else if (accept || illegal_hit) begin
            rdata_q <= (legal && !core_we_i) ? mem.mem_rd : 32'd0;
            off_q   <= core_addr_i[1:0];
            size_q  <= core_size_i;
            err_q   <= !legal;
        end
    end

    lsu_load_extract u_load_extract (
        .rdata_q (rdata_q),
        .off_q   (off_q),
        .size_q  (size_q),
        .ext_o   (ext_word)
    );

    assign core_rd_o   = ((state_q == DONE) && !err_q) ? ext_word : 32'd0;
    assign lsu_err_o   = (state_q == DONE) && err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a transaction-level model predicts each cycle's
// outputs and a single negedge process compares the DUT against it.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    localparam int PH_NONE  = 0;
    localparam int PH_RESET = 1;
    localparam int PH_IDLE  = 2;
    localparam int PH_REQ   = 3;
    localparam int PH_DONE  = 4;
    localparam logic [31:0] JUNK = 32'hA5C3_3C5A;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        lsu_err_o;
    lsu_state_t  dbg_state_o;

    riscv_lsu_if mem_bus();

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .lsu_err_o    (lsu_err_o),
        .dbg_state_o  (dbg_state_o),
        .mem          (mem_bus)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int exp_phase = PH_NONE;
    int stall_cnt = 0;

    logic        m_we;
    logic        m_legal;
    logic        m_chk_rd;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic        lit_en;
    logic [31:0] lit;
    logic [3:0]  lit_be;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_legal(input logic we, input logic [2:0] size, input logic [31:0] addr);
        if (size == 3 || size == 6 || size == 7) return 1'b0;
        if (we && (size == 4 || size == 5)) return 1'b0;
        if ((size == 1 || size == 5) && (addr % 2 != 0)) return 1'b0;
        if (size == 2 && (addr % 4 != 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] f_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (!we) return 4'hF;
        if (size == 0) return 4'(1 << off);
        if (size == 1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] size, input logic [31:0] wd);
        if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] word, input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        if (size == 0 || size == 4) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (size == 0 && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (size == 1 || size == 5) begin
            v = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (size == 1 && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return word;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk_i) begin
        if (core_stall_o) stall_cnt++;
        case (exp_phase)
            PH_RESET: begin
                check("rst_req",   32'(mem_bus.mem_req), 32'd0);
                check("rst_we",    32'(mem_bus.mem_we), 32'd0);
                check("rst_be",    32'(mem_bus.mem_be), 32'd0);
                check("rst_stall", 32'(core_stall_o), 32'd0);
                check("rst_rd",    core_rd_o, 32'd0);
                check("rst_err",   32'(lsu_err_o), 32'd0);
                check("rst_state", 32'(dbg_state_o), 32'(IDLE));
            end
            PH_IDLE: begin
                check("idle_req",   32'(mem_bus.mem_req), 32'd0);
                check("idle_stall", 32'(core_stall_o), 32'd0);
                check("idle_err",   32'(lsu_err_o), 32'd0);
                check("idle_be",    32'(mem_bus.mem_be), 32'd0);
                check("idle_state", 32'(dbg_state_o), 32'(IDLE));
            end
            PH_REQ: begin
                check("req_stall", 32'(core_stall_o), 32'd1);
                check("req_req",   32'(mem_bus.mem_req), 32'(m_legal));
                check("req_err",   32'(lsu_err_o), 32'd0);
                if (m_legal) begin
                    check("req_we",   32'(mem_bus.mem_we), 32'(m_we));
                    check("req_be",   32'(mem_bus.mem_be), 32'(m_be));
                    check("req_addr", mem_bus.mem_addr, m_addr);
                    if (m_we) check("req_wd", mem_bus.mem_wd, m_wd);
                    if (lit_en && m_we) begin
                        check("lit_be", 32'(mem_bus.mem_be), 32'(lit_be));
                        check("lit_wd", mem_bus.mem_wd, lit);
                    end
                end else begin
                    check("req_we_ill", 32'(mem_bus.mem_we), 32'd0);
                    check("req_be_ill", 32'(mem_bus.mem_be), 32'd0);
                end
            end
            PH_DONE: begin
                check("done_req",   32'(mem_bus.mem_req), 32'd0);
                check("done_we",    32'(mem_bus.mem_we), 32'd0);
                check("done_stall", 32'(core_stall_o), 32'd0);
                check("done_err",   32'(lsu_err_o), 32'(!m_legal));
                check("done_state", 32'(dbg_state_o), 32'(DONE));
                if (m_chk_rd) begin
                    if (exp_q.size() == 0) begin
                        check("done_rd_q_empty", 32'd1, 32'd0);
                    end else begin
                        check("done_rd", core_rd_o, exp_q.pop_front());
                    end
                end
                if (lit_en && !m_we) check("lit_rd", core_rd_o, lit);
            end
            default: ;
        endcase
    end

    // ---------------- driver ----------------
    task automatic load_model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] word);
        m_we     = we;
        m_addr   = addr;
        m_legal  = f_legal(we, size, addr);
        m_be     = f_be(we, size, addr);
        m_wd     = f_wd(size, wd);
        m_chk_rd = !we || !m_legal;
        if (m_chk_rd) exp_q.push_back(m_legal ? f_load(word, size, addr) : 32'd0);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
    endtask

    // Called at posedge+1 while the DUT is in IDLE; returns at posedge+1 of the next IDLE.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int wait_n,
                          input logic l_en, input logic [31:0] l_val, input logic [3:0] l_be);
        lit_en = l_en;
        lit    = l_val;
        lit_be = l_be;
        load_model(we, size, addr, wd, word);
        stall_cnt = 0;
        exp_phase = PH_REQ;
        if (!m_legal) begin
            mem_bus.mem_ready = 1'b1;
            mem_bus.mem_rd    = JUNK;
        end else begin
            mem_bus.mem_ready = (wait_n == 0);
            mem_bus.mem_rd    = (wait_n == 0) ? word : JUNK;
        end
        @(posedge clk_i); #1;
        if (m_legal) begin
            for (int k = 1; k <= wait_n; k++) begin
                mem_bus.mem_ready = (k == wait_n);
                mem_bus.mem_rd    = (k == wait_n) ? word : JUNK;
                @(posedge clk_i); #1;
            end
        end
        exp_phase = PH_DONE;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rd    = JUNK;
        @(posedge clk_i); #1;
        check("stall_cycles", 32'(stall_cnt), m_legal ? 32'(1 + wait_n) : 32'd1);
        core_req_i = 1'b0;
        mem_bus.mem_ready = 1'b0;
        lit_en    = 1'b0;
        exp_phase = PH_IDLE;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'd0; core_wd_i = 32'd0;
        mem_bus.mem_rd = 32'd0; mem_bus.mem_ready = 1'b0;
        m_we = 1'b0; m_legal = 1'b1; m_chk_rd = 1'b0; m_addr = 32'd0; m_wd = 32'd0; m_be = 4'd0;
        lit_en = 1'b0; lit = 32'd0; lit_be = 4'd0;
        exp_phase = PH_RESET;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_phase = PH_IDLE;
        @(posedge clk_i); #1;

        //      we    size     addr          wd            word          wait lit  value          be
        access(1'b0, LDST_W,  32'h100, 32'h0,         32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF, 4'h0);
        access(1'b1, LDST_B,  32'h103, 32'h000000A5,  32'h0,        0, 1'b1, 32'hA5A5A5A5, 4'h8);
        access(1'b1, LDST_H,  32'h102, 32'h00001234,  32'h0,        0, 1'b1, 32'h12341234, 4'hC);
        access(1'b0, LDST_B,  32'h200, 32'h0,         32'h80F0FF7F, 0, 1'b1, 32'h0000007F, 4'h0);
        access(1'b0, LDST_B,  32'h201, 32'h0,         32'h80F0FF7F, 0, 1'b1, 32'hFFFFFFFF, 4'h0);
        access(1'b0, LDST_BU, 32'h202, 32'h0,         32'h80F0FF7F, 0, 1'b1, 32'h000000F0, 4'h0);
        access(1'b0, LDST_H,  32'h202, 32'h0,         32'h80F0FF7F, 0, 1'b1, 32'hFFFF80F0, 4'h0);
        access(1'b0, LDST_HU, 32'h202, 32'h0,         32'h80F0FF7F, 0, 1'b1, 32'h000080F0, 4'h0);
        access(1'b0, LDST_B,  32'h203, 32'h0,         32'h80F0FF7F, 1, 1'b1, 32'hFFFFFF80, 4'h0);
        access(1'b0, LDST_H,  32'h200, 32'h0,         32'h80F0FF7F, 2, 1'b1, 32'hFFFFFF7F, 4'h0);
        access(1'b0, LDST_W,  32'h300, 32'h0,         32'h13579BDF, 3, 1'b1, 32'h13579BDF, 4'h0);
        access(1'b1, LDST_W,  32'h304, 32'hCAFEF00D,  32'h0,        1, 1'b1, 32'hCAFEF00D, 4'hF);
        access(1'b1, LDST_B,  32'h305, 32'h0000003C,  32'h0,        0, 1'b1, 32'h3C3C3C3C, 4'h2);
        access(1'b1, LDST_H,  32'h300, 32'hFFFF5678,  32'h0,        2, 1'b1, 32'h56785678, 4'h3);
        // Illegal accesses: misaligned, reserved size codes, unsigned stores.
        access(1'b0, LDST_W,  32'h102, 32'h0,         32'h11111111, 0, 1'b1, 32'h00000000, 4'h0);
        access(1'b1, LDST_H,  32'h101, 32'h00001234,  32'h0,        0, 1'b0, 32'h0,        4'h0);
        access(1'b0, LDST_HU, 32'h103, 32'h0,         32'h22222222, 0, 1'b1, 32'h00000000, 4'h0);
        access(1'b0, 3'd3,    32'h100, 32'h0,         32'h33333333, 0, 1'b1, 32'h00000000, 4'h0);
        access(1'b1, LDST_BU, 32'h100, 32'h000000FF,  32'h0,        0, 1'b0, 32'h0,        4'h0);
        access(1'b0, 3'd7,    32'h104, 32'h0,         32'h44444444, 0, 1'b1, 32'h00000000, 4'h0);

        // Reset while waiting on the memory.
        load_model(1'b0, LDST_W, 32'h400, 32'h0, 32'h0);
        void'(exp_q.pop_back());
        exp_phase = PH_REQ;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rd    = JUNK;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("wait_state", 32'(dbg_state_o), 32'(WAIT));
        exp_phase = PH_NONE;
        #2 rst_i = 1'b0;
        #1;
        check("rst_wait_req",   32'(mem_bus.mem_req), 32'd0);
        check("rst_wait_stall", 32'(core_stall_o), 32'd0);
        check("rst_wait_state", 32'(dbg_state_o), 32'(IDLE));
        exp_phase = PH_RESET;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        rst_i = 1'b1;
        exp_phase = PH_IDLE;
        @(posedge clk_i); #1;
        access(1'b0, LDST_W,  32'h400, 32'h0,         32'h0BADF00D, 1, 1'b1, 32'h0BADF00D, 4'h0);
        access(1'b0, LDST_HU, 32'h402, 32'h0,         32'hFEDC1234, 0, 1'b1, 32'h0000FEDC, 4'h0);

        exp_phase = PH_NONE;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
